// File: rtl/rgbw_pwm_gen_pkg.sv
// Shared constants for the RGBW PWM generator: widths, channel indices and
// the phase-stagger step used when RGBW_PWM_PHASE_STAGGER_EN is defined.
package rgbw_pwm_gen_pkg;

  localparam int unsigned PWM_WIDTH        = 8;
  localparam int unsigned PWM_NUM_CH       = 4;
  localparam int unsigned PWM_STAGGER_STEP = 2 ** (PWM_WIDTH - 2);

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2,
    CH_W = 2'd3
  } ch_e;

  // Quarter-period offset of channel ch for a counter of the given width.
  function automatic int unsigned stagger_offset(int unsigned ch, int unsigned width);
    return ch << (width - 2);
  endfunction

endpackage

// File: rtl/rgbw_pwm_gen_channel.sv
// One PWM channel: active-duty register updated at period wrap plus a
// registered comparator against the (optionally offset) period counter.
module pwm_channel_cmp
  import rgbw_pwm_gen_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt,
  input  logic             wrap,
  input  logic [WIDTH-1:0] shadow,
  input  logic [WIDTH-1:0] offset,
  output logic             pwm
);

  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] cnt_ch;

  always_comb cnt_ch = cnt + offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wrap) active <= shadow;
      pwm <= (cnt_ch < active);
    end
  end

endmodule

// File: rtl/rgbw_pwm_gen.sv
// Four-channel RGBW PWM generator clocked by prescaler ticks, with
// wrap-synchronous duty updates. Optional RGBW_PWM_PHASE_STAGGER_EN staggers channels.
module rgbw_pwm_gen
  import rgbw_pwm_gen_pkg::*;
#(
  parameter int unsigned WIDTH  = PWM_WIDTH,
  parameter int unsigned NUM_CH = PWM_NUM_CH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    presc_clk,
  input  logic [NUM_CH*WIDTH-1:0] duty_in,
  input  logic                    load,
  output logic                    pending,
  output logic                    period_start,
  output logic [NUM_CH-1:0]       pwm_out
);

  logic             presc_q;
  logic             armed;
  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow [NUM_CH];

  // armed blocks a tick from a presc_clk level that was already high when
  // reset released; it sets once presc_clk has been seen low.
  always_comb begin
    tick = presc_clk & ~presc_q & armed;
    wrap = tick & (cnt == '1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= 1'b0;
      armed        <= 1'b0;
      cnt          <= '0;
      pending      <= 1'b0;
      period_start <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      presc_q      <= presc_clk;
      armed        <= armed | ~presc_clk;
      period_start <= wrap;
      if (tick) cnt <= cnt + WIDTH'(1);
      // A load coinciding with wrap keeps pending set: the channels take the
      // old shadow now and the new value at the following wrap.
      if (load) begin
        for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= duty_in[i*WIDTH +: WIDTH];
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef RGBW_PWM_PHASE_STAGGER_EN
    localparam logic [WIDTH-1:0] OFFSET = WIDTH'(stagger_offset(i, WIDTH));
`else
    localparam logic [WIDTH-1:0] OFFSET = '0;
`endif
    pwm_channel_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clk    (clk),
      .reset  (reset),
      .cnt    (cnt),
      .wrap   (wrap),
      .shadow (shadow[i]),
      .offset (OFFSET),
      .pwm    (pwm_out[i])
    );
  end

endmodule

// File: doc/rgbw_pwm_gen.md
Name: rgbw_pwm_gen

Overview:
- Four-channel (R, G, B, W) PWM generator directly downstream of the PWM prescaler.
- Consumes the prescaler's square-wave output `presc_clk` as a timebase. Every rising edge of `presc_clk`, detected in the `clk` domain, advances a shared period counter.
- Duty values are loaded through a strobe into shadow registers. They take effect only at period wrap, so output pulses are never glitched or truncated.
- Outputs drive the LED driver pins.

Parameters:
- WIDTH, 8, duty/counter resolution in bits; the PWM period is 2^WIDTH ticks.
- NUM_CH, 4, channel count, fixed at 4 (R=0, G=1, B=2, W=3).

Ports:
- clk  in  1  system clock, the single clock domain.
- reset  in  1  synchronous reset, active-high.
- presc_clk  in  1  prescaled square wave from the clock divider, synchronous to clk.
- duty_in  in  NUM_CH*WIDTH  packed duties, with channel i at bits [i*WIDTH +: WIDTH].
- load  in  1  single-cycle strobe; captures duty_in into the shadow registers.
- pending  out  1  high while shadow duties are waiting for the next period wrap.
- period_start  out  1  one-clk pulse when the counter wraps to 0.
- pwm_out  out  NUM_CH  PWM outputs, registered.

Behaviour:
- Reset values (synchronous, reset=1 at a clk edge):
  - cnt=0, presc_q=0.
  - shadow[i]=0, active[i]=0.
  - pending=0, period_start=0, pwm_out=0.
  - Reset asserted mid-period aborts the period immediately; outputs are low on the next clk.
- Tick generation:
  - presc_q <= presc_clk.
  - tick = presc_clk & ~presc_q.
  - Exactly one tick per presc_clk rising edge, never on a level.
  - A presc_clk already high when reset releases produces no tick until its next rising edge.
- Counter:
  - On tick, cnt <= cnt+1, with a WIDTH-bit unsigned wrap from 2^WIDTH-1 to 0.
  - The counter holds between ticks.
- Wrap event: wrap = tick & (cnt == 2^WIDTH-1). On wrap:
  - active <= shadow.
  - pending <= 0.
  - period_start <= 1 for one clk.
- Load:
  - load=1 sets shadow <= duty_in and pending <= 1.
  - Loads during a period overwrite each other; the last one before the wrap wins.
  - If load and wrap occur in the same clk:
    - active takes the old shadow.
    - shadow takes the new duty_in.
    - pending stays 1, and the new value applies at the following wrap.
- Compare, registered with 1 clk latency: pwm_out[i] <= (cnt < active[i]), evaluated every clk.
- Duty rules:
  - duty 0 gives output constantly low.
  - duty d gives d ticks high per 2^WIDTH ticks.
  - duty 2^WIDTH-1 gives high for all but one tick.
  - A 100 % duty is not representable, by design.
- Outputs change only on a counter change or an active update, so there are no mid-period glitches.

Optional Feature:
- Macro: RGBW_PWM_PHASE_STAGGER_EN.
- Defined:
  - The compare uses a per-channel offset count: cnt_i = cnt + i*2^(WIDTH-2), mod 2^WIDTH.
  - With WIDTH=8 the offsets are 0/64/128/192, so channel edges are staggered to reduce simultaneous switching current.
  - Duty ratio and period are unchanged.
  - active still updates at the global wrap; staggered channels may therefore show one transition period mixing old and new duty.
- Undefined: all channels compare against cnt directly; rising edges of nonzero channels are aligned at cnt=0.

Decomposition:
- Shared package holds:
  - PWM_WIDTH=8 and PWM_NUM_CH=4.
  - Channel index constants CH_R=0, CH_G=1, CH_B=2, CH_W=3.
  - Stagger offset constant PWM_STAGGER_STEP = 2^(PWM_WIDTH-2).
- Sub-module pwm_channel_cmp (one per channel):
  - Contains the active-duty register and the registered comparator.
  - Inputs: cnt, wrap, shadow duty, channel offset.
  - Instantiated NUM_CH times.
- The top level owns tick detection, the counter, the shadow registers, the pending flag and period_start.

Test Plan:
- Reset then idle, presc_clk toggling every 2 clk (tick every 4 clk):
  - pwm_out = 0000 and pending = 0 throughout.
  - period_start pulses every 1024 clk.
- Load R=64, G=128, B=0, W=255 mid-period:
  - pending = 1 until the next wrap; outputs unchanged until then.
  - Over the next full period, high time per channel = 256 / 512 / 0 / 1020 clk.
- Load 10 then load 200 within one period:
  - Only 200 is applied at the wrap.
- Load asserted on the exact wrap clk:
  - The old shadow is applied now.
  - The new value is applied one period later; pending stays 1 across the wrap.
- Assert reset while R=128 is active mid-high-phase:
  - pwm_out[0] = 0 one clk later; cnt = 0 and active = 0 after reset.
  - With presc_clk already high at reset release, the first tick comes only on the next presc_clk rising edge.
- With RGBW_PWM_PHASE_STAGGER_EN defined, all duties 32:
  - Rising edges at cnt = 0 / 192 / 128 / 64 for channels R / G / B / W (cnt_i = 0 at those cnt values).
  - Each channel is high 128 clk per period.
